// File: rtl/mmu_pkg.sv
// Shared definitions for the cache tag clear sequencer: FSM state encoding
// and the tag RAM clear-address width.
package mmu_pkg;

    // Width of the clear address bus (covers the largest supported DEPTH).
    localparam int ADDR_W = 11;

    // Width of the CPU starve counter (covers STARVE_LIM up to 15).
    localparam int STARVE_W = 4;

    // Sequencer states: idle, walking the tag RAM, and the one-cycle finish slot.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        FIN   = 2'd2
    } clr_state_e;

endpackage : mmu_pkg

// File: rtl/mmu_cache_clear_seq_if.sv
// Tag RAM arbitration bus between a requester (CPU side / clear initiator)
// and the clear sequencer.
interface mmu_cache_clear_seq_if;
    import mmu_pkg::*;

    logic              clr_req;
    logic              cpu_req;
    logic              cpu_gnt;
    logic [ADDR_W-1:0] ca;
    logic              cwr;
    logic              cclr_n;
    logic              busy;
    logic              done;

    // Requester side: raises clear and CPU requests, observes grants and status.
    modport master (
        output clr_req, cpu_req,
        input  cpu_gnt, ca, cwr, cclr_n, busy, done
    );

    // Sequencer side: receives requests, drives grants, clear slot and status.
    modport slave (
        input  clr_req, cpu_req,
        output cpu_gnt, ca, cwr, cclr_n, busy, done
    );

endinterface : mmu_cache_clear_seq_if

// File: rtl/mmu_clr_arb.sv
// Per-cycle tag RAM owner decision during a clear: the CPU wins until it has
// taken STARVE_LIM consecutive slots, then the clear gets one write slot.
module mmu_clr_arb
    import mmu_pkg::*;
#(
    parameter int STARVE_LIM = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_clear_i,
    input  logic cpu_req_i,
    output logic cpu_gnt_o,
    output logic clr_wr_o
);

    localparam logic [STARVE_W-1:0] LIM = STARVE_W'(STARVE_LIM);

    logic [STARVE_W-1:0] starve_q, starve_d;

    // Grant decision, combinational from the starve count and the CPU request.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        cpu_gnt_o = 1'b0;
        clr_wr_o  = 1'b0;
        if (in_clear_i) begin
            cpu_gnt_o = cpu_req_i && (starve_q < LIM);
            clr_wr_o  = !cpu_gnt_o;
        end else begin
            // Outside a clear the CPU has the RAM whenever it asks, except in reset.
            cpu_gnt_o = cpu_req_i && rst_n;
        end
    end

    // Starve count: counts CPU wins within a clear, cleared by any clear write.
    always_comb begin
        starve_d = starve_q;
        if (!in_clear_i || clr_wr_o) begin
            starve_d = '0;
        end else if (cpu_gnt_o) begin
            starve_d = starve_q + STARVE_W'(1);
        end
    end

    // Starve count register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: asynchronous active-low reset; state updates use non-blocking
        // assignments so all registers see pre-edge values.
        if (!rst_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule : mmu_clr_arb

// File: rtl/mmu_cache_clear_seq.sv
// Cache tag clear sequencer: on a clear request walks every tag entry,
// writing the invalid pattern, while sharing the tag RAM with the CPU.
module mmu_cache_clear_seq
    import mmu_pkg::*;
#(
    parameter int DEPTH      = 2048,
    parameter int STARVE_LIM = 4
) (
    input  logic              sysclk,
    input  logic              sys_rst_n,
    input  logic              CLR_REQ,
    input  logic              CPU_REQ,
    output logic              CPU_GNT,
    output logic [ADDR_W-1:0] CA_10_0,
    output logic              CWR,
    output logic              CCLR_n,
    output logic              BUSY,
    output logic              DONE
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              pend_q, pend_d;
    logic              clr_wr;
    logic              cpu_gnt;

    mmu_clr_arb #(
        .STARVE_LIM (STARVE_LIM)
    ) u_arb (
        .clk        (sysclk),
        .rst_n      (sys_rst_n),
        .in_clear_i (state_q == CLEAR),
        .cpu_req_i  (CPU_REQ),
        .cpu_gnt_o  (cpu_gnt),
        .clr_wr_o   (clr_wr)
    );

    // Next state, clear address and pending-request flag.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        pend_d  = pend_q;
        unique case (state_q)
            IDLE: begin
                if (CLR_REQ) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                end
            end
            CLEAR: begin
                // Requests during a walk collapse into a single restart.
                if (CLR_REQ) begin
                    pend_d = 1'b1;
                end
                if (clr_wr) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = FIN;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            FIN: begin
                // A request seen during the walk or in this slot restarts at once.
                if (pend_q || CLR_REQ) begin
                    state_d = CLEAR;
                    addr_d  = '0;
                    pend_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer registers; a reset abandons any walk in progress.
    always_ff @(posedge sysclk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
        end
    end

    assign CPU_GNT = cpu_gnt;
    assign CWR     = clr_wr;
    assign CCLR_n  = ~clr_wr;
    assign CA_10_0 = clr_wr ? addr_q : '0;
    assign BUSY    = (state_q != IDLE);
    assign DONE    = (state_q == FIN);

endmodule : mmu_cache_clear_seq

// File: tb/tb_mmu_cache_clear_seq.sv
// Self-checking bench for mmu_cache_clear_seq (DEPTH=16, STARVE_LIM=4):
// directed scenarios plus randomized traffic against a behavioural model.
module tb_mmu_cache_clear_seq;
    import mmu_pkg::*;

    localparam int DEPTH = 16;
    localparam int LIM   = 4;

    logic sysclk;
    logic sys_rst_n;

    mmu_cache_clear_seq_if bus ();

    mmu_cache_clear_seq #(
        .DEPTH      (DEPTH),
        .STARVE_LIM (LIM)
    ) dut (
        .sysclk    (sysclk),
        .sys_rst_n (sys_rst_n),
        .CLR_REQ   (bus.clr_req),
        .CPU_REQ   (bus.cpu_req),
        .CPU_GNT   (bus.cpu_gnt),
        .CA_10_0   (bus.ca),
        .CWR       (bus.cwr),
        .CCLR_n    (bus.cclr_n),
        .BUSY      (bus.busy),
        .DONE      (bus.done)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model: a walk is "entries written so far" plus a run of CPU wins.
    bit m_walking;   // a clear walk is in progress
    int m_written;   // entries already cleared in this walk
    int m_cpu_run;   // consecutive CPU wins since the last clear write
    bit m_again;     // another clear was asked for during this walk
    bit m_fin;       // the done slot follows the last write

    task automatic m_reset();
        m_walking = 0; m_written = 0; m_cpu_run = 0; m_again = 0; m_fin = 0;
    endtask

    task automatic m_start();
        m_walking = 1; m_written = 0; m_cpu_run = 0; m_again = 0; m_fin = 0;
    endtask

    // Observation counters for the directed scenarios.
    int  o_cyc, o_wr, o_done, o_first_wr, o_done_at, o_walk_cyc, o_walk_gnt, o_gap_idle;
    logic last_gnt, last_cwr, last_busy;
    logic [ADDR_W-1:0] last_ca;

    task automatic reset_obs();
        o_cyc = 0; o_wr = 0; o_done = 0; o_first_wr = -1; o_done_at = -1;
        o_walk_cyc = 0; o_walk_gnt = 0; o_gap_idle = 0;
    endtask

    // One clock: drive inputs after the falling edge, compare against the model,
    // then advance the model to where the next rising edge takes it.
    task automatic cycle(input logic clr, input logic cpu);
        logic e_gnt, e_wr, e_busy, e_done;
        int   e_ca;
        @(negedge sysclk);
        bus.clr_req = clr;
        bus.cpu_req = cpu;
        #1;
        e_gnt = 0; e_wr = 0; e_busy = 0; e_done = 0; e_ca = 0;
        if (sys_rst_n) begin
            if (m_walking) begin
                e_busy = 1;
                e_gnt  = cpu && (m_cpu_run < LIM);
                e_wr   = !e_gnt;
                e_ca   = e_wr ? m_written : 0;
            end else begin
                e_gnt  = cpu;
                e_busy = m_fin;
                e_done = m_fin;
            end
        end
        check("cpu_gnt", bus.cpu_gnt, e_gnt);
        check("cwr", bus.cwr, e_wr);
        check("cclr_n", bus.cclr_n, !e_wr);
        check("ca", bus.ca, e_ca);
        check("busy", bus.busy, e_busy);
        check("done", bus.done, e_done);

        last_gnt = bus.cpu_gnt; last_cwr = bus.cwr; last_ca = bus.ca; last_busy = bus.busy;
        if (bus.cwr) begin
            o_wr++;
            if (o_first_wr < 0) o_first_wr = o_cyc;
        end
        if (bus.done) begin
            o_done++;
            if (o_done_at < 0) o_done_at = o_cyc;
        end
        if (bus.busy && !bus.done) begin
            o_walk_cyc++;
            if (bus.cpu_gnt) o_walk_gnt++;
        end
        if (o_done == 1 && !bus.busy) o_gap_idle++;
        o_cyc++;

        if (sys_rst_n) begin
            if (m_walking) begin
                if (clr) m_again = 1;
                if (e_gnt) begin
                    m_cpu_run++;
                end else begin
                    m_cpu_run = 0;
                    m_written++;
                    if (m_written == DEPTH) begin
                        m_walking = 0;
                        m_fin = 1;
                    end
                end
            end else if (m_fin) begin
                if (m_again || clr) m_start();
                else m_fin = 0;
            end else if (clr) begin
                m_start();
            end
        end
    endtask

    // Asynchronous reset in mid-cycle; outputs must fall at once.
    task automatic do_reset();
        @(negedge sysclk);
        bus.clr_req = 1'b0;
        bus.cpu_req = 1'b1;
        #2;
        sys_rst_n = 1'b0;
        m_reset();
        #1;
        check("rst_gnt", bus.cpu_gnt, 0);
        check("rst_cwr", bus.cwr, 0);
        check("rst_cclr_n", bus.cclr_n, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_ca", bus.ca, 0);
        repeat (2) cycle(1'b0, 1'b1);
        @(negedge sysclk);
        bus.cpu_req = 1'b0;
        sys_rst_n   = 1'b1;
    endtask

    // Every cycle: one owner at most, and the invalid-pattern select mirrors CWR.
    always begin
        @(negedge sysclk);
        #2;
        check("excl_gnt_cwr", bus.cpu_gnt && bus.cwr, 0);
        check("cclr_inv_cwr", bus.cclr_n, !bus.cwr);
    end

    initial begin
        bit sent7, sent9;
        sys_rst_n   = 1'b0;
        bus.clr_req = 1'b0;
        bus.cpu_req = 1'b0;
        m_reset();
        #1;
        check("init_busy", bus.busy, 0);
        check("init_cwr", bus.cwr, 0);
        check("init_gnt", bus.cpu_gnt, 0);
        repeat (2) cycle(1'b0, 1'b0);
        @(negedge sysclk);
        sys_rst_n = 1'b1;

        // Uncontended clear: 16 back-to-back writes, DONE one cycle later.
        reset_obs();
        cycle(1'b1, 1'b0);
        repeat (24) cycle(1'b0, 1'b0);
        check("plain_writes", o_wr, DEPTH);
        check("plain_first_wr", o_first_wr, 1);
        check("plain_done_cnt", o_done, 1);
        check("plain_done_at", o_done_at, DEPTH + 1);
        check("plain_busy_after", last_busy, 0);

        // CPU always requesting: 4 grants then 1 write, 80 clear cycles.
        reset_obs();
        cycle(1'b1, 1'b1);
        repeat (100) cycle(1'b0, 1'b1);
        check("starve_walk_cyc", o_walk_cyc, DEPTH * (LIM + 1));
        check("starve_walk_gnt", o_walk_gnt, DEPTH * LIM);
        check("starve_writes", o_wr, DEPTH);
        check("starve_done_at", o_done_at, DEPTH * (LIM + 1) + 1);

        // Requests at address 7 and 9 collapse into one back-to-back restart.
        reset_obs();
        sent7 = 0; sent9 = 0;
        cycle(1'b1, 1'b0);
        repeat (60) begin
            if (m_walking && m_written == 7 && !sent7) begin
                sent7 = 1;
                cycle(1'b1, 1'b0);
            end else if (m_walking && m_written == 9 && !sent9) begin
                sent9 = 1;
                cycle(1'b1, 1'b0);
            end else begin
                cycle(1'b0, 1'b0);
            end
        end
        check("restart_done_cnt", o_done, 2);
        check("restart_writes", o_wr, 2 * DEPTH);
        check("restart_idle_gap", o_gap_idle, 0);

        // Reset while writing address 5: no DONE, next clear starts at 0.
        reset_obs();
        cycle(1'b1, 1'b0);
        for (int i = 0; i < 20 && !(m_walking && m_written == 5); i++) cycle(1'b0, 1'b0);
        check("rst_at_addr5", m_written, 5);
        do_reset();
        reset_obs();
        repeat (20) cycle(1'b0, 1'b0);
        check("rst_no_done", o_done, 0);
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        check("rst_restart_cwr", last_cwr, 1);
        check("rst_restart_ca", last_ca, 0);
        repeat (20) cycle(1'b0, 1'b0);

        // CLR_REQ with CPU_REQ in IDLE: CPU granted now, first write at 0 next.
        reset_obs();
        cycle(1'b1, 1'b1);
        check("coinc_gnt", last_gnt, 1);
        cycle(1'b0, 1'b0);
        check("coinc_cwr", last_cwr, 1);
        check("coinc_ca", last_ca, 0);
        repeat (20) cycle(1'b0, 1'b0);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 29) == 0), logic'($urandom_range(0, 1)));
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_mmu_cache_clear_seq
